lamp_seq_monitor: RTL and testbench

//  Passive checker on the lamp outputs of the traffic-light controller (man/std/ind, 3 bits each).

---
 rtl/lsm_pkg.sv | 46 ++++
 rtl/lamp_seq_checker.sv | 82 ++++++++
 rtl/lamp_seq_monitor.sv | 100 ++++++++++
 tb/tb_lamp_seq_monitor.sv | 207 ++++++++++++++++++++
 4 files changed

// File: rtl/lsm_pkg.sv
// Shared definitions for the lamp sequence monitor: lamp codes, checker
// phase states, err_flags bit positions and first_chan channel ids.
package lsm_pkg;

    localparam logic [2:0] LAMP_RED = 3'b100;
    localparam logic [2:0] LAMP_RY  = 3'b110;
    localparam logic [2:0] LAMP_GRN = 3'b001;
    localparam logic [2:0] LAMP_YEL = 3'b010;

    typedef enum logic [2:0] {PH_INIT, PH_RED, PH_RY, PH_GRN, PH_YEL} phase_e;

    localparam int ERR_CODE  = 0;
    localparam int ERR_TRANS = 1;
    localparam int ERR_DWELL = 2;
    localparam int ERR_CONFL = 3;
    localparam int ERR_STUCK = 4;
    localparam int NUM_ERR   = 5;

    localparam logic [1:0] CH_MAN   = 2'd0;
    localparam logic [1:0] CH_STD   = 2'd1;
    localparam logic [1:0] CH_IND   = 2'd2;
    localparam logic [1:0] CH_CONFL = 2'd3;

    // Map a raw lamp vector to a phase; PH_INIT marks an illegal code.
    function automatic phase_e code2phase(input logic [2:0] code);
        case (code)
            LAMP_RED: return PH_RED;
            LAMP_RY:  return PH_RY;
            LAMP_GRN: return PH_GRN;
            LAMP_YEL: return PH_YEL;
            default:  return PH_INIT;
        endcase
    endfunction

    // Only legal successor of a phase; pedestrians just toggle RED/GRN.
    function automatic phase_e next_phase(input phase_e ph, input logic ped);
        case (ph)
            PH_RED:  return ped ? PH_GRN : PH_RY;
            PH_RY:   return PH_GRN;
            PH_GRN:  return ped ? PH_RED : PH_YEL;
            PH_YEL:  return PH_RED;
            default: return PH_INIT;
        endcase
    endfunction

endpackage

// File: rtl/lamp_seq_checker.sv
// Per-channel phase tracker. Event outputs are combinational strobes for
// the current sample; the top level registers them.
// Watchdog is built only with LSM_STUCK_TIMEOUT_EN.
module lamp_seq_checker
    import lsm_pkg::*;
#(
    parameter bit PED       = 1'b0,
    parameter int MIN_DWELL = 4,
    parameter int MAX_DWELL = 64,
    parameter int DWELL_W   = 8
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [2:0] lamp_in,
    output logic       bad_code,
    output logic       bad_trans,
    output logic       short_dwell,
    output logic       stuck,
    output phase_e     phase,
    output logic       wrap_yel_red
);

    phase_e               phase_q, phase_d;
    logic [DWELL_W-1:0]   dwell_q, dwell_d;
    phase_e               new_ph;
    logic                 legal;
    logic                 held;

    // Classify the sample, then track phase and dwell and raise events.
    always_comb begin
        new_ph       = code2phase(lamp_in);
        legal        = (new_ph != PH_INIT) &&
                       (!PED || new_ph == PH_RED || new_ph == PH_GRN);
        held         = 1'b0;
        phase_d      = phase_q;
        dwell_d      = dwell_q;
        bad_code     = 1'b0;
        bad_trans    = 1'b0;
        short_dwell  = 1'b0;
        wrap_yel_red = 1'b0;
        if (!legal) begin
            bad_code = 1'b1;
        end else if (phase_q == PH_INIT) begin
            phase_d = new_ph;
            dwell_d = DWELL_W'(1);
        end else if (new_ph == phase_q) begin
            held = 1'b1;
            if (dwell_q != {DWELL_W{1'b1}})
                dwell_d = dwell_q + DWELL_W'(1);
        end else begin
            // state follows the new code even when the order was wrong
            bad_trans    = (new_ph != next_phase(phase_q, PED));
            short_dwell  = (dwell_q < DWELL_W'(MIN_DWELL));
            wrap_yel_red = (phase_q == PH_YEL) && (new_ph == PH_RED);
            phase_d      = new_ph;
            dwell_d      = DWELL_W'(1);
        end
    end

`ifdef LSM_STUCK_TIMEOUT_EN
    // Fires once per phase, on the sample where dwell reaches MAX_DWELL.
    always_comb begin
        stuck = !PED && held && (dwell_q == DWELL_W'(MAX_DWELL - 1));
    end
`else
    assign stuck = 1'b0;
`endif

    // Phase/dwell registers; reset returns the checker to INIT.
    always_ff @(posedge clk) begin
        if (rst) begin
            phase_q <= PH_INIT;
            dwell_q <= '0;
        end else begin
            phase_q <= phase_d;
            dwell_q <= dwell_d;
        end
    end

    assign phase = phase_q;

endmodule

// File: rtl/lamp_seq_monitor.sv
// Passive lamp-sequence monitor for the traffic-light controller.
// Three per-channel checkers (man/std/ind) plus the pedestrian/vehicle
// conflict check, sticky error flags, first-failing channel and a count of
// completed std cycles. Optional watchdog: define LSM_STUCK_TIMEOUT_EN.
module lamp_seq_monitor
    import lsm_pkg::*;
#(
    parameter int MIN_DWELL = 4,
    parameter int MAX_DWELL = 64,
    parameter int DWELL_W   = 8,
    parameter int CNT_W     = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [2:0]       man_in,
    input  logic [2:0]       std_in,
    input  logic [2:0]       ind_in,
    output logic [4:0]       err_flags,
    output logic             err_pulse,
    output logic [1:0]       first_chan,
    output logic [CNT_W-1:0] cycle_cnt
);

    localparam int NCH = 3;

    logic [NCH-1:0][2:0] lamps;
    logic [NCH-1:0]      bad_code, bad_trans, short_dwell, stuck, wrap;
    logic [NCH-1:0]      chan_err;
    phase_e              phase [NCH];

    assign lamps = {ind_in, std_in, man_in};

    for (genvar g = 0; g < NCH; g++) begin : g_chk
        lamp_seq_checker #(
            .PED       (g == 0),
            .MIN_DWELL (MIN_DWELL),
            .MAX_DWELL (MAX_DWELL),
            .DWELL_W   (DWELL_W)
        ) u_chk (
            .clk          (clk),
            .rst          (rst),
            .lamp_in      (lamps[g]),
            .bad_code     (bad_code[g]),
            .bad_trans    (bad_trans[g]),
            .short_dwell  (short_dwell[g]),
            .stuck        (stuck[g]),
            .phase        (phase[g]),
            .wrap_yel_red (wrap[g])
        );
        assign chan_err[g] = bad_code[g] | bad_trans[g] | short_dwell[g] | stuck[g];
    end

    logic [4:0]       err_flags_q, err_flags_d, new_err;
    logic             err_pulse_q, err_pulse_d;
    logic [1:0]       first_chan_q, first_chan_d;
    logic [CNT_W-1:0] cycle_cnt_q, cycle_cnt_d;
    logic             conflict;

    // Merge this sample's violations into the sticky flags and capture origin.
    always_comb begin
        conflict = (man_in == LAMP_GRN) && (std_in != LAMP_RED || ind_in != LAMP_RED);
        new_err             = '0;
        new_err[ERR_CODE]   = |bad_code;
        new_err[ERR_TRANS]  = |bad_trans;
        new_err[ERR_DWELL]  = |short_dwell;
        new_err[ERR_CONFL]  = conflict;
        new_err[ERR_STUCK]  = |stuck;
        err_flags_d  = err_flags_q | new_err;
        err_pulse_d  = |new_err;
        first_chan_d = first_chan_q;
        if (err_flags_q == '0 && new_err != '0) begin
            if (conflict)               first_chan_d = CH_CONFL;
            else if (chan_err[CH_MAN])  first_chan_d = CH_MAN;
            else if (chan_err[CH_STD])  first_chan_d = CH_STD;
            else                        first_chan_d = CH_IND;
        end
        cycle_cnt_d = cycle_cnt_q + CNT_W'(wrap[CH_STD]);
    end

    // Output registers; reset wins over every update.
    always_ff @(posedge clk) begin
        if (rst) begin
            err_flags_q  <= '0;
            err_pulse_q  <= 1'b0;
            first_chan_q <= '0;
            cycle_cnt_q  <= '0;
        end else begin
            err_flags_q  <= err_flags_d;
            err_pulse_q  <= err_pulse_d;
            first_chan_q <= first_chan_d;
            cycle_cnt_q  <= cycle_cnt_d;
        end
    end

    assign err_flags  = err_flags_q;
    assign err_pulse  = err_pulse_q;
    assign first_chan = first_chan_q;
    assign cycle_cnt  = cycle_cnt_q;

endmodule

// File: tb/tb_lamp_seq_monitor.sv
// Bench for lamp_seq_monitor: directed scenarios then randomized lamp
// traffic, every cycle compared against a rule-level reference model.
module tb_lamp_seq_monitor;

    localparam logic [2:0] R  = 3'b100;
    localparam logic [2:0] RY = 3'b110;
    localparam logic [2:0] G  = 3'b001;
    localparam logic [2:0] Y  = 3'b010;
    localparam int MIN_D = 4;
    localparam int MAX_D = 64;

    logic        clk = 1'b0;
    logic        rst;
    logic [2:0]  man, std, ind;
    logic [4:0]  err_flags;
    logic        err_pulse;
    logic [1:0]  first_chan;
    logic [15:0] cycle_cnt;

    int tests = 0;
    int fails = 0;

    lamp_seq_monitor dut (
        .clk(clk), .rst(rst), .man_in(man), .std_in(std), .ind_in(ind),
        .err_flags(err_flags), .err_pulse(err_pulse),
        .first_chan(first_chan), .cycle_cnt(cycle_cnt)
    );

    always #5 clk = ~clk;

    // reference model state: last legal code per channel (-1 = none) and hold length
    int          m_last [3];
    int          m_hold [3];
    logic [4:0]  e_flags;
    logic        e_pulse;
    logic [1:0]  e_first;
    logic [15:0] e_cnt;

    function automatic bit is_legal(input int c, input logic [2:0] code);
        if (c == 0) return (code == R || code == G);
        return (code == R || code == RY || code == G || code == Y);
    endfunction

    function automatic logic [2:0] succ(input int c, input logic [2:0] code);
        if (c == 0) return (code == R) ? G : R;
        case (code)
            R:       return RY;
            RY:      return G;
            G:       return Y;
            default: return R;
        endcase
    endfunction

    task automatic model_step();
        logic [2:0] v [3];
        logic [4:0] nw;
        bit         ce [3];
        bool_conf: begin end
        v[0] = man; v[1] = std; v[2] = ind;
        nw = '0;
        if (rst) begin
            for (int c = 0; c < 3; c++) begin m_last[c] = -1; m_hold[c] = 0; end
            e_flags = '0; e_pulse = 1'b0; e_first = '0; e_cnt = '0;
            return;
        end
        for (int c = 0; c < 3; c++) begin
            ce[c] = 1'b0;
            if (!is_legal(c, v[c])) begin
                nw[0] = 1'b1; ce[c] = 1'b1;
            end else if (m_last[c] < 0) begin
                m_last[c] = int'(v[c]); m_hold[c] = 1;
            end else if (int'(v[c]) == m_last[c]) begin
                if (m_hold[c] < 255) m_hold[c]++;
`ifdef LSM_STUCK_TIMEOUT_EN
                if (c != 0 && m_hold[c] == MAX_D && m_hold[c] != 255) begin
                    nw[4] = 1'b1; ce[c] = 1'b1;
                end
`endif
            end else begin
                if (v[c] != succ(c, 3'(m_last[c]))) begin nw[1] = 1'b1; ce[c] = 1'b1; end
                if (m_hold[c] < MIN_D) begin nw[2] = 1'b1; ce[c] = 1'b1; end
                if (c == 1 && m_last[c] == int'(Y) && v[c] == R) e_cnt++;
                m_last[c] = int'(v[c]); m_hold[c] = 1;
            end
        end
        if (man == G && (std != R || ind != R)) nw[3] = 1'b1;
        e_pulse = (nw != 0);
        if (e_flags == 0 && nw != 0) begin
            if (nw[3])      e_first = 2'd3;
            else if (ce[0]) e_first = 2'd0;
            else if (ce[1]) e_first = 2'd1;
            else            e_first = 2'd2;
        end
        e_flags |= nw;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Apply one sample, let the model see it at the edge, compare after the edge.
    task automatic step(input logic [2:0] m, input logic [2:0] s, input logic [2:0] i,
                        input logic r);
        man = m; std = s; ind = i; rst = r;
        @(posedge clk);
        model_step();
        #1;
        chk("flags", 32'(err_flags), 32'(e_flags));
        chk("pulse", 32'(err_pulse), 32'(e_pulse));
        chk("first", 32'(first_chan), 32'(e_first));
        chk("cnt",   32'(cycle_cnt), 32'(e_cnt));
    endtask

    task automatic rep(input int n, input logic [2:0] m, input logic [2:0] s,
                       input logic [2:0] i);
        for (int k = 0; k < n; k++) step(m, s, i, 1'b0);
    endtask

    initial begin
        logic [2:0] cur [3];
        int         rr;

        // reset state
        step(R, R, R, 1'b1);
        chk("reset_flags", 32'(err_flags), 32'd0);
        chk("reset_cnt",   32'(cycle_cnt), 32'd0);

        // 1: legal std cycle
        rep(5, R, R, R); rep(5, R, RY, R); rep(5, R, G, R); rep(5, R, Y, R);
        step(R, R, R, 1'b0);
        chk("t1_flags", 32'(err_flags), 32'd0);
        chk("t1_cnt",   32'(cycle_cnt), 32'd1);

        // 2: std GRN -> RED skips YEL
        step(R, R, R, 1'b1);
        rep(5, R, G, R);
        step(R, R, R, 1'b0);
        chk("t2_flags", 32'(err_flags), 32'b00010);
        chk("t2_first", 32'(first_chan), 32'd1);
        chk("t2_pulse", 32'(err_pulse), 32'd1);
        step(R, R, R, 1'b0);
        chk("t2_pulse_drop", 32'(err_pulse), 32'd0);

        // 3: ind RY held only 2 samples
        step(R, R, R, 1'b1);
        rep(4, R, R, R); rep(2, R, R, RY);
        step(R, R, G, 1'b0);
        chk("t3_dwell", 32'(err_flags[2]), 32'd1);
        chk("t3_first", 32'(first_chan), 32'd2);

        // 4: man GRN against non-red std that also jumps GRN -> RY
        step(R, R, R, 1'b1);
        rep(4, R, R, R); rep(4, R, RY, R); rep(4, R, G, R);
        step(G, RY, R, 1'b0);
        chk("t4_confl", 32'(err_flags[3]), 32'd1);
        chk("t4_trans", 32'(err_flags[1]), 32'd1);
        chk("t4_first", 32'(first_chan), 32'd3);

        // 5: bad man code keeps first_chan, then reset clears everything
        step(3'b011, RY, R, 1'b0);
        chk("t5_code",  32'(err_flags[0]), 32'd1);
        chk("t5_first", 32'(first_chan), 32'd3);
        step(R, RY, R, 1'b1);
        chk("t5_rst_flags", 32'(err_flags), 32'd0);
        chk("t5_rst_first", 32'(first_chan), 32'd0);
        step(R, G, R, 1'b0);
        chk("t5_init_flags", 32'(err_flags), 32'd0);

        // 6: long std GRN hold
        step(R, R, R, 1'b1);
        rep(70, R, G, R);
`ifdef LSM_STUCK_TIMEOUT_EN
        chk("t6_stuck", 32'(err_flags[4]), 32'd1);
`else
        chk("t6_nostuck", 32'(err_flags), 32'd0);
`endif

        // randomized lamp traffic with occasional resets
        step(R, R, R, 1'b1);
        for (int c = 0; c < 3; c++) cur[c] = R;
        for (int n = 0; n < 3000; n++) begin
            for (int c = 0; c < 3; c++) begin
                rr = int'($urandom_range(99));
                if (rr >= 80 && rr < 96)
                    cur[c] = is_legal(c, cur[c]) ? succ(c, cur[c]) : R;
                else if (rr >= 96)
                    cur[c] = 3'($urandom_range(7));
            end
            step(cur[0], cur[1], cur[2], ($urandom_range(79) == 0));
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    // keep a broken DUT from running forever
    initial begin
        #2000000;
        $display("FAIL timeout tests=%0d", tests);
        $fatal(1, "timeout");
    end

endmodule
